// File: rtl/gpu_rasterizer_pkg.sv
// gpu_rasterizer_pkg
//   Shared types for the rasterizer slice. It provides:
//   - gpu_op_t, the draw command popped from the CPU op FIFO.
//   - The bit positions of the fields in a sprite ROM texel.
//   - The rasterizer FSM state encoding.
//   - Internal widths used by the walker.
package gpu_rasterizer_pkg;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] width;
    logic [10:0] height;
    logic        color;
    logic        mem_en;
    logic        scale;
    logic [15:0] mem_addr;
  } gpu_op_t;

  // Sprite ROM texel layout: {opaque, colour}
  localparam int TEXEL_OPAQUE_BIT = 1;
  localparam int TEXEL_COLOR_BIT  = 0;

  // Output span counters must hold (2047 << 1) - 1.
  localparam int SPAN_W = 12;
  // Absolute pixel position: 11-bit origin plus a 12-bit span offset, sized so it never wraps.
  localparam int POS_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_BLIT  = 2'd2,
    ST_DRAIN = 2'd3
  } rast_state_t;

endpackage

// File: rtl/gpu_rasterizer_rect_walker.sv
// gpu_rasterizer_rect_walker
//   Walks the output rectangle of one draw op in raster order (column fastest).
//   Every address is kept as a running sum, so the walk needs no multipliers. The
//   only product is the constant y*HOR_ACTIVE_PIXELS at load time, which reduces to
//   shifts and adds.
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   ce_i         clock enable; the walker holds while it is low
//   start_i      load a new op (origin, size, scale, ROM base) and reset to pixel 0
//   step_i       advance to the next output pixel
//   x_i, y_i     op origin
//   width_i      op width in texels (also the sprite ROM row pitch)
//   height_i     op height in texels
//   scale_i      1 = 2x magnification
//   mem_addr_i   sprite ROM base address
//   fb_addr_o    framebuffer address of the current pixel
//   rom_addr_o   sprite ROM address of the texel under the current pixel
//   in_bounds_o  the current pixel lies inside the active area
//   last_o       the current pixel is the last one of the rectangle
module gpu_rasterizer_rect_walker
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FB_ADDR_WIDTH     = 19,
  parameter int ROM_ADDR_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce_i,
  input  logic                      start_i,
  input  logic                      step_i,
  input  logic [10:0]               x_i,
  input  logic [10:0]               y_i,
  input  logic [10:0]               width_i,
  input  logic [10:0]               height_i,
  input  logic                      scale_i,
  input  logic [ROM_ADDR_WIDTH-1:0] mem_addr_i,
  output logic [FB_ADDR_WIDTH-1:0]  fb_addr_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  output logic                      in_bounds_o,
  output logic                      last_o
);

  logic [SPAN_W-1:0]         col_q, row_q;
  logic [SPAN_W-1:0]         wlast_q, hlast_q;
  logic [POS_W-1:0]          px_q, py_q;
  logic [10:0]               x_q;
  logic [10:0]               width_q;
  logic                      scale_q;
  logic [FB_ADDR_WIDTH-1:0]  fb_addr_q, fb_row_q;
  logic [ROM_ADDR_WIDTH-1:0] rom_row_q;

  logic [FB_ADDR_WIDTH-1:0]  fb_base_d;
  logic                      row_end_d;

  // Addresses of off-screen origins may wrap. Such pixels are never written, so the
  // wrap is harmless, and on-screen pixels stay exact.
  assign fb_base_d = FB_ADDR_WIDTH'(32'(y_i) * 32'(HOR_ACTIVE_PIXELS) + 32'(x_i));
  assign row_end_d = (col_q == wlast_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      wlast_q   <= '0;
      hlast_q   <= '0;
      px_q      <= '0;
      py_q      <= '0;
      x_q       <= '0;
      width_q   <= '0;
      scale_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_row_q  <= '0;
      rom_row_q <= '0;
    end else if (ce_i) begin
      if (start_i) begin
        col_q     <= '0;
        row_q     <= '0;
        wlast_q   <= ({1'b0, width_i} << scale_i) - 12'd1;
        hlast_q   <= ({1'b0, height_i} << scale_i) - 12'd1;
        px_q      <= POS_W'(x_i);
        py_q      <= POS_W'(y_i);
        x_q       <= x_i;
        width_q   <= width_i;
        scale_q   <= scale_i;
        fb_addr_q <= fb_base_d;
        fb_row_q  <= fb_base_d;
        rom_row_q <= mem_addr_i;
      end else if (step_i) begin
        if (row_end_d) begin
          col_q     <= '0;
          row_q     <= row_q + 12'd1;
          px_q      <= POS_W'(x_q);
          py_q      <= py_q + 13'd1;
          fb_row_q  <= fb_row_q + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
          fb_addr_q <= fb_row_q + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
          // At 2x, each texel row covers two output rows, so the ROM row base moves
          // only after the odd output row.
          if (!scale_q || row_q[0])
            rom_row_q <= rom_row_q + ROM_ADDR_WIDTH'(width_q);
        end else begin
          col_q     <= col_q + 12'd1;
          px_q      <= px_q + 13'd1;
          fb_addr_q <= fb_addr_q + FB_ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign fb_addr_o   = fb_addr_q;
  assign rom_addr_o  = rom_row_q + ROM_ADDR_WIDTH'(col_q >> scale_q);
  assign in_bounds_o = (px_q < POS_W'(HOR_ACTIVE_PIXELS)) &&
                       (py_q < POS_W'(VER_ACTIVE_PIXELS));
  assign last_o      = row_end_d && (row_q == hlast_q);

endmodule

// File: rtl/gpu_rasterizer.sv
// gpu_rasterizer
//   Pops draw commands from a first-word-fall-through op FIFO and writes pixels into
//   the back framebuffer.
//   - Solid ops fill a rectangle with op.color.
//   - Sprite ops blit texels from the sprite ROM. They support optional 2x scaling
//     and per-texel transparency.
//   - Every write is clipped to the active area.
// Ports
//   clk, rst    clock and asynchronous active-high reset
//   ce          clock enable; state holds and the write/pop strobes are forced low
//   op          FIFO head (gpu_op_t)
//   op_empty    FIFO empty
//   op_rd_en    one-cycle pop of the FIFO head
//   rom_addr    sprite ROM read address
//   rom_data    texel {opaque, colour}, valid one cycle after rom_addr
//   fb_wr_en    framebuffer write strobe
//   fb_wr_addr  framebuffer write address, y*HOR_ACTIVE_PIXELS + x
//   fb_wr_data  pixel colour
//   idle        no op in progress and FIFO empty
module gpu_rasterizer
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FB_ADDR_WIDTH     = 19,
  parameter int ROM_ADDR_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  gpu_op_t                   op,
  input  logic                      op_empty,
  output logic                      op_rd_en,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [1:0]                rom_data,
  output logic                      fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0]  fb_wr_addr,
  output logic                      fb_wr_data,
  output logic                      idle
);

  rast_state_t               state_q;
  logic                      color_q;
  // Blit write pipeline: the pixel whose texel is on rom_data this cycle.
  logic                      vld_p1_q;
  logic                      inb_p1_q;
  logic [FB_ADDR_WIDTH-1:0]  addr_p1_q;

  logic                      pop_d;
  logic                      step_d;
  logic                      op_zero_d;
  logic [FB_ADDR_WIDTH-1:0]  walk_fb_addr;
  logic [ROM_ADDR_WIDTH-1:0] walk_rom_addr;
  logic                      walk_inb;
  logic                      walk_last;

  assign pop_d     = ce && !rst && (state_q == ST_IDLE) && !op_empty;
  assign step_d    = (state_q == ST_FILL) || (state_q == ST_BLIT);
  assign op_zero_d = (op.width == 11'd0) || (op.height == 11'd0);

  gpu_rasterizer_rect_walker #(
    .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
    .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
    .FB_ADDR_WIDTH     (FB_ADDR_WIDTH),
    .ROM_ADDR_WIDTH    (ROM_ADDR_WIDTH)
  ) u_walker (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce),
    .start_i     (pop_d),
    .step_i      (step_d),
    .x_i         (op.x),
    .y_i         (op.y),
    .width_i     (op.width),
    .height_i    (op.height),
    .scale_i     (op.scale),
    .mem_addr_i  (op.mem_addr),
    .fb_addr_o   (walk_fb_addr),
    .rom_addr_o  (walk_rom_addr),
    .in_bounds_o (walk_inb),
    .last_o      (walk_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      color_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      inb_p1_q  <= 1'b0;
      addr_p1_q <= '0;
    end else if (ce) begin
      // Stage p0 -> p1: the ROM address was issued this cycle, so its texel returns next cycle.
      vld_p1_q  <= (state_q == ST_BLIT);
      inb_p1_q  <= walk_inb;
      addr_p1_q <= walk_fb_addr;

      unique case (state_q)
        ST_IDLE: begin
          if (!op_empty) begin
            color_q <= op.color;
            // A zero-area op is consumed here without walking anything.
            if (!op_zero_d)
              state_q <= op.mem_en ? ST_BLIT : ST_FILL;
          end
        end
        ST_FILL:  if (walk_last) state_q <= ST_IDLE;
        ST_BLIT:  if (walk_last) state_q <= ST_DRAIN;
        ST_DRAIN: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_rd_en = pop_d;
  assign idle     = (state_q == ST_IDLE) && op_empty;
  assign rom_addr = (state_q == ST_BLIT) ? walk_rom_addr : '0;

  always_comb begin
    fb_wr_en   = 1'b0;
    fb_wr_addr = '0;
    fb_wr_data = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        fb_wr_en   = ce && walk_inb;
        fb_wr_addr = walk_fb_addr;
        fb_wr_data = color_q;
      end
      ST_BLIT, ST_DRAIN: begin
        fb_wr_en   = ce && vld_p1_q && inb_p1_q && rom_data[TEXEL_OPAQUE_BIT];
        fb_wr_addr = addr_p1_q;
        fb_wr_data = rom_data[TEXEL_COLOR_BIT];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpu_rasterizer.sv
module tb_gpu_rasterizer;
  import gpu_rasterizer_pkg::*;

  localparam int FBW = 19;
  localparam int RAW = 16;

  logic           clk;
  logic           rst;
  logic           ce;
  gpu_op_t        op;
  logic           op_empty;
  logic           op_rd_en;
  logic [RAW-1:0] rom_addr;
  logic [1:0]     rom_data;
  logic           fb_wr_en;
  logic [FBW-1:0] fb_wr_addr;
  logic           fb_wr_data;
  logic           idle;

  gpu_op_t    ops [0:15];
  int         head = 0;
  int         tail = 0;
  logic [1:0] rom [0:63];

  int checks   = 0;
  int failures = 0;

  gpu_rasterizer dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .op         (op),
    .op_empty   (op_empty),
    .op_rd_en   (op_rd_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First-word-fall-through FIFO model
  always_comb begin
    op_empty = (head >= tail);
    op       = op_empty ? '0 : ops[head[3:0]];
  end
  always @(posedge clk) if (op_rd_en) head <= head + 1;

  // Synchronous sprite ROM: data one cycle after address
  always @(posedge clk) rom_data <= rom[rom_addr[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input int addr, input logic data);
    chk({tag, "_en"}, 32'(fb_wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(fb_wr_addr), 32'(addr));
    chk({tag, "_data"}, 32'(fb_wr_data), 32'(data));
  endtask

  task automatic expect_nowr(input string tag);
    chk({tag, "_en"}, 32'(fb_wr_en), 32'd0);
  endtask

  task automatic push(input gpu_op_t o);
    ops[tail[3:0]] = o;
    tail = tail + 1;
  endtask

  function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                 input logic color, input logic mem_en, input logic scale,
                                 input int maddr);
    gpu_op_t o;
    o.x        = 11'(x);
    o.y        = 11'(y);
    o.width    = 11'(w);
    o.height   = 11'(h);
    o.color    = color;
    o.mem_en   = mem_en;
    o.scale    = scale;
    o.mem_addr = 16'(maddr);
    return o;
  endfunction

  initial begin
    int fa[6];
    int sa[8];
    logic sd[8];
    int sr[8];

    rst = 1'b1;
    ce  = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 2'd0;
    rom[0]  = 2'd3; rom[1]  = 2'd2;
    rom[8]  = 2'd3; rom[9]  = 2'd0; rom[10] = 2'd2; rom[11] = 2'd3;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(op_rd_en), 32'd0);
    chk("rst_wr_en", 32'(fb_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(fb_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(fb_wr_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_idle", 32'(idle), 32'd1);

    // Solid fill 3x2 at origin
    fa = '{0, 1, 2, 640, 641, 642};
    push(mk(0, 0, 3, 2, 1'b1, 1'b0, 1'b0, 0));
    #1 chk("f1_pop", 32'(op_rd_en), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_wr($sformatf("f1_px%0d", i), fa[i], 1'b1);
      chk($sformatf("f1_nopop%0d", i), 32'(op_rd_en), 32'd0);
      if (i == 0) chk("f1_busy", 32'(idle), 32'd0);
    end
    @(negedge clk);
    expect_nowr("f1_done");
    chk("f1_idle", 32'(idle), 32'd1);

    // Fill straddling the bottom-right corner: only 2 of 8 pixels land
    push(mk(638, 479, 4, 2, 1'b1, 1'b0, 1'b0, 0));
    #1 chk("f2_pop", 32'(op_rd_en), 32'd1);
    @(negedge clk); expect_wr("f2_px0", 479 * 640 + 638, 1'b1);
    @(negedge clk); expect_wr("f2_px1", 479 * 640 + 639, 1'b1);
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      expect_nowr($sformatf("f2_clip%0d", i));
    end
    @(negedge clk);
    chk("f2_idle", 32'(idle), 32'd1);
    expect_nowr("f2_done");

    // Blit 2x2, scale 0, ROM 8..11 = {3,0,2,3}
    push(mk(20, 100, 2, 2, 1'b0, 1'b1, 1'b0, 8));
    #1 chk("b1_pop", 32'(op_rd_en), 32'd1);
    @(negedge clk);
    chk("b1_ra0", 32'(rom_addr), 32'd8);
    expect_nowr("b1_lat");
    @(negedge clk);
    chk("b1_ra1", 32'(rom_addr), 32'd9);
    expect_wr("b1_w0", 64020, 1'b1);
    @(negedge clk);
    chk("b1_ra2", 32'(rom_addr), 32'd10);
    expect_nowr("b1_transp");
    @(negedge clk);
    chk("b1_ra3", 32'(rom_addr), 32'd11);
    expect_wr("b1_w2", 64660, 1'b0);
    @(negedge clk);
    expect_wr("b1_w3", 64661, 1'b1);
    @(negedge clk);
    expect_nowr("b1_done");
    chk("b1_idle", 32'(idle), 32'd1);

    // Blit 2x1 at 2x scale, ROM {3,2} -> 4x2 output
    sa = '{0, 1, 2, 3, 640, 641, 642, 643};
    sd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    sr = '{0, 0, 1, 1, 0, 0, 1, 1};
    push(mk(0, 0, 2, 1, 1'b0, 1'b1, 1'b1, 0));
    #1 chk("b2_pop", 32'(op_rd_en), 32'd1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) chk($sformatf("b2_ra%0d", i), 32'(rom_addr), 32'(sr[i]));
      if (i == 0) expect_nowr("b2_lat");
      else expect_wr($sformatf("b2_w%0d", i - 1), sa[i - 1], sd[i - 1]);
    end
    @(negedge clk);
    expect_nowr("b2_done");
    chk("b2_idle", 32'(idle), 32'd1);

    // Zero-width op followed by a 1x1 fill
    push(mk(3, 3, 0, 3, 1'b1, 1'b0, 1'b0, 0));
    push(mk(5, 0, 1, 1, 1'b1, 1'b0, 1'b0, 0));
    #1 chk("z_pop0", 32'(op_rd_en), 32'd1);
    @(negedge clk);
    chk("z_pop1", 32'(op_rd_en), 32'd1);
    expect_nowr("z_nowr");
    @(negedge clk);
    expect_wr("z_fill", 5, 1'b1);
    @(negedge clk);
    expect_nowr("z_done");
    chk("z_idle", 32'(idle), 32'd1);

    // Clock enable stall mid-fill
    push(mk(0, 2, 4, 1, 1'b1, 1'b0, 1'b0, 0));
    #1 chk("c_pop", 32'(op_rd_en), 32'd1);
    @(negedge clk); expect_wr("c_px0", 1280, 1'b1);
    @(negedge clk); expect_wr("c_px1", 1281, 1'b1);
    ce = 1'b0;
    #1 expect_nowr("c_gate");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_nowr($sformatf("c_hold%0d", i));
      chk($sformatf("c_nopop%0d", i), 32'(op_rd_en), 32'd0);
    end
    ce = 1'b1;
    #1 expect_wr("c_res1", 1281, 1'b1);
    @(negedge clk); expect_wr("c_px2", 1282, 1'b1);
    @(negedge clk); expect_wr("c_px3", 1283, 1'b1);
    @(negedge clk);
    expect_nowr("c_done");
    chk("c_idle", 32'(idle), 32'd1);

    // Reset asserted mid-blit
    push(mk(20, 100, 2, 2, 1'b0, 1'b1, 1'b0, 8));
    #1 chk("r_pop", 32'(op_rd_en), 32'd1);
    @(negedge clk);
    chk("r_ra0", 32'(rom_addr), 32'd8);
    @(negedge clk);
    expect_wr("r_w0", 64020, 1'b1);
    rst = 1'b1;
    #1;
    chk("r_wr_en", 32'(fb_wr_en), 32'd0);
    chk("r_wr_addr", 32'(fb_wr_addr), 32'd0);
    chk("r_wr_data", 32'(fb_wr_data), 32'd0);
    chk("r_rom_addr", 32'(rom_addr), 32'd0);
    chk("r_rd_en", 32'(op_rd_en), 32'd0);
    chk("r_idle", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_nowr($sformatf("r_after%0d", i));
      chk($sformatf("r_after_idle%0d", i), 32'(idle), 32'd1);
      chk($sformatf("r_after_rd%0d", i), 32'(op_rd_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
